shift_exec_stage: RTL and testbench
===================================

Name: shift_exec_stage

Overview:
- Two-stage execute pipeline for MIPS register-shift instructions: sll, srl, sra, sllv, srlv, srav.
- Decodes the instruction and registers operands to drive the combinational shifter directly downstream (sh_A/sh_B/sh_Shiftop).
- Captures sh_Result into a writeback-facing result register.
- valid/ready handshakes on both sides; full throughput of 1 instruction/cycle; synchronous flush.

Parameters:
- DATA_WIDTH, 32, operand/result width; shift amount is always 5 bits.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of both stages
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage accepts this cycle
- in_inst  input  32  MIPS instruction word
- in_rs_val  input  DATA_WIDTH  rs register value
- in_rt_val  input  DATA_WIDTH  rt register value
- sh_A  output  DATA_WIDTH  shifter operand (value to shift)
- sh_B  output  5  shifter shift amount
- sh_Shiftop  output  2  shifter op: 00 sll, 01 srl, 11 sra
- sh_Result  input  DATA_WIDTH  shifter combinational result
- out_valid  output  1  result valid to writeback
- out_ready  input  1  writeback accepts
- out_result  output  DATA_WIDTH  shift result
- out_waddr  output  5  destination rd
- out_wen  output  1  register write enable
- out_illegal  output  1  instruction was not a supported shift

Behaviour:
- Decode (combinational, on in_inst):
  - shift = (opcode==0) && funct in {00_0000, 00_0010, 00_0011, 00_0100, 00_0110, 00_0111}
  - Shiftop = {funct[0], funct[1]}
  - B = funct[2] ? rs_val[4:0] : inst[10:6]
  - A = rt_val
  - rd = inst[15:11]
  - wen = shift && (rd != 0)
  - illegal = !shift
  - Illegal instructions carry Shiftop=00, A=0, B=0.
- E1 register:
  - Holds valid1, A, B, Shiftop, rd, wen, illegal.
  - sh_A/sh_B/sh_Shiftop are driven directly from E1 registers (no combinational path from in_*).
- E2 register:
  - Holds valid2, result (= sh_Result sampled when E1 advances), rd, wen, illegal.
  - Drives all out_* ports.
- Handshake:
  - adv2 = !valid2 || out_ready
  - adv1 = !valid1 || adv2
  - in_ready = adv1 && !rst && !flush
  - Transfer occurs when in_valid && in_ready.
  - E2 loads from E1 when adv2. valid2 <= valid1.
  - E1 loads from the decoder when adv1. valid1 <= in_valid && in_ready.
  - Registers not advancing hold their value.
  - out_* and sh_* are stable while valid && !ready.
- Latency:
  - Accept at edge N produces out_valid high after edge N+1, with sh_Result sampled at N+1.
  - With out_ready held high, 1 result per cycle, in order.
- Backpressure: with out_ready low, at most 2 instructions are buffered; in_ready drops once both stages are valid. There is no loss and no duplication.
- Flush:
  - At the edge, clears valid1 and valid2. Data registers hold.
  - flush overrides acceptance and advancement in the same cycle.
- Reset:
  - All registers cleared to 0, so out_valid = out_result = out_waddr = out_wen = out_illegal = 0 and sh_A = sh_B = sh_Shiftop = 0.
  - Reset mid-operation discards in-flight instructions.
  - in_ready = 1 in the first cycle after rst deasserts.
- Illegal instructions still occupy a slot and emerge with out_illegal=1, out_wen=0, out_result=0. E2 forces result 0 when illegal.
- Shift amounts 0 and 31 pass through unmodified. For sllv/srlv/srav, only rs_val[4:0] is used; upper bits are ignored.

Decomposition:
- Shared header: funct codes (FUNCT_SLL/SRL/SRA/SLLV/SRLV/SRAV), SHIFTOP_SLL=00/SRL=01/SRA=11, OPCODE_SPECIAL=0.
- One combinational sub-module, shift_decode: in_inst, rs_val, rt_val -> A, B, Shiftop, rd, wen, illegal.
- The shifter itself stays external, connected via sh_* at the top level.

Test Plan:
- sll rd3,rt2,4 (0x00021900), rt_val=0x000000F1, out_ready=1 -> out_result=0x00000F10, out_waddr=3, out_wen=1, out_valid exactly 2 edges after acceptance.
- sra rd3,rt2,8 (0x00021A03), rt_val=0x80000000 -> sh_Shiftop=11, sh_B=8, out_result=0xFF800000. srlv rd3,rt2,rs1 (0x00221806), rs_val=0xFFFFFFE4, rt_val=0x80000000 -> sh_B=4, out_result=0x08000000.
- Three back-to-back sll instructions with out_ready=0 for 4 cycles -> in_ready low after two are buffered; outputs held stable; all three delivered in order once out_ready=1, with no gaps.
- addu 0x00221821 -> out_illegal=1, out_wen=0, out_result=0. sll rd0 (0x00020100) -> out_wen=0, out_illegal=0.
- Two instructions in flight, flush=1 for one cycle with in_valid=1 -> out_valid=0 next cycle, nothing accepted; the next instruction proceeds normally. Repeat with rst instead of flush -> all outputs 0.

Source files
------------

// File: rtl/shift_exec_stage_pkg.sv
// Shared encodings for the register-shift execute stage: MIPS opcode/funct
// values, shifter op codes and the decoded control bundle.
package shift_exec_stage_pkg;

    localparam logic [5:0] OPCODE_SPECIAL = 6'h00;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;

    localparam logic [1:0] SHIFTOP_SLL = 2'b00;
    localparam logic [1:0] SHIFTOP_SRL = 2'b01;
    localparam logic [1:0] SHIFTOP_SRA = 2'b11;

    // Control fields carried alongside the operand through E1
    typedef struct packed {
        logic [4:0] b;
        logic [1:0] shiftop;
        logic [4:0] rd;
        logic       wen;
        logic       illegal;
    } shift_ctrl_t;

    function automatic logic is_shift_funct(input logic [5:0] funct);
        case (funct)
            FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
            FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: is_shift_funct = 1'b1;
            default:                            is_shift_funct = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shift_exec_stage_decode.sv
// Combinational decode of a MIPS shift instruction into shifter operands and
// writeback control. Unsupported instructions decode to a zeroed operation.
module shift_decode
    import shift_exec_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           inst,
    input  logic [DATA_WIDTH-1:0] rs_val,
    input  logic [DATA_WIDTH-1:0] rt_val,
    output logic [DATA_WIDTH-1:0] a,
    output shift_ctrl_t           ctrl
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_shift;
    logic       unused_bits;

    assign opcode   = inst[31:26];
    assign funct    = inst[5:0];
    assign is_shift = (opcode == OPCODE_SPECIAL) && is_shift_funct(funct);

    // Variable shifts only look at the low five bits of rs; the rs/rt fields
    // of the word itself are already resolved into rs_val/rt_val upstream.
    assign unused_bits = ^{rs_val[DATA_WIDTH-1:5], inst[25:16]};

    always_comb begin
        a            = '0;
        ctrl         = '0;
        ctrl.rd      = inst[15:11];
        ctrl.illegal = !is_shift;
        if (is_shift) begin
            a            = rt_val;
            ctrl.shiftop = {funct[0], funct[1]};
            ctrl.b       = funct[2] ? rs_val[4:0] : inst[10:6];
            ctrl.wen     = (inst[15:11] != 5'd0);
        end
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage execute pipeline for MIPS register shifts: E1 drives the external
// shifter from registers, E2 captures its result for writeback.
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [DATA_WIDTH-1:0] in_rs_val,
    input  logic [DATA_WIDTH-1:0] in_rt_val,
    output logic [DATA_WIDTH-1:0] sh_A,
    output logic [4:0]            sh_B,
    output logic [1:0]            sh_Shiftop,
    input  logic [DATA_WIDTH-1:0] sh_Result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [4:0]            out_waddr,
    output logic                  out_wen,
    output logic                  out_illegal
);

    localparam int STAGES = 2;

    logic [STAGES:1]       vld_pipe;
    logic                  adv1;
    logic                  adv2;
    logic                  fire;

    logic [DATA_WIDTH-1:0] dec_a;
    shift_ctrl_t           dec_ctrl;

    logic [DATA_WIDTH-1:0] e1_a;
    shift_ctrl_t           e1_ctrl;

    logic [DATA_WIDTH-1:0] e2_result;
    logic [4:0]            e2_rd;
    logic                  e2_wen;
    logic                  e2_illegal;

    shift_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .inst   (in_inst),
        .rs_val (in_rs_val),
        .rt_val (in_rt_val),
        .a      (dec_a),
        .ctrl   (dec_ctrl)
    );

    // A stage may load when it is empty or its successor is moving
    assign adv2     = !vld_pipe[2] || out_ready;
    assign adv1     = !vld_pipe[1] || adv2;
    assign in_ready = adv1 && !rst && !flush;
    assign fire     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            e1_a       <= '0;
            e1_ctrl    <= '0;
            e2_result  <= '0;
            e2_rd      <= '0;
            e2_wen     <= 1'b0;
            e2_illegal <= 1'b0;
        end else if (flush) begin
            // Kill in-flight work; payload registers keep their contents
            vld_pipe <= '0;
        end else begin
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                e2_result   <= e1_ctrl.illegal ? '0 : sh_Result;
                e2_rd       <= e1_ctrl.rd;
                e2_wen      <= e1_ctrl.wen;
                e2_illegal  <= e1_ctrl.illegal;
            end
            if (adv1) begin
                vld_pipe[1] <= fire;
                e1_a        <= dec_a;
                e1_ctrl     <= dec_ctrl;
            end
        end
    end

    assign sh_A        = e1_a;
    assign sh_B        = e1_ctrl.b;
    assign sh_Shiftop  = e1_ctrl.shiftop;

    assign out_valid   = vld_pipe[2];
    assign out_result  = e2_result;
    assign out_waddr   = e2_rd;
    assign out_wen     = e2_wen;
    assign out_illegal = e2_illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage with a behavioural shifter attached to
// the sh_* interface.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [31:0] sh_A;
    logic [4:0]  sh_B;
    logic [1:0]  sh_Shiftop;
    logic [31:0] sh_Result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_waddr;
    logic        out_wen;
    logic        out_illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_exec_stage #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_rs_val   (in_rs_val),
        .in_rt_val   (in_rt_val),
        .sh_A        (sh_A),
        .sh_B        (sh_B),
        .sh_Shiftop  (sh_Shiftop),
        .sh_Result   (sh_Result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_waddr   (out_waddr),
        .out_wen     (out_wen),
        .out_illegal (out_illegal)
    );

    // External shifter
    always_comb begin
        case (sh_Shiftop)
            2'b00:   sh_Result = sh_A << sh_B;
            2'b01:   sh_Result = sh_A >> sh_B;
            2'b11:   sh_Result = $unsigned($signed(sh_A) >>> sh_B);
            default: sh_Result = sh_A;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_rs_val = '0; in_rt_val = '0;
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %h want 0", out_valid); end
        n_cmp++; if (out_result !== 32'h0) begin n_err++; $display("FAIL rst_out_result got %h want 0", out_result); end
        n_cmp++; if ({out_waddr, out_wen, out_illegal} !== 7'h0) begin n_err++; $display("FAIL rst_out_ctrl got %h want 0", {out_waddr, out_wen, out_illegal}); end
        n_cmp++; if ({sh_A, sh_B, sh_Shiftop} !== 39'h0) begin n_err++; $display("FAIL rst_sh got %h want 0", {sh_A, sh_B, sh_Shiftop}); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready_hi got %h want 0", in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready_after got %h want 1", in_ready); end
    endtask

    task automatic test_sll();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00021900; in_rs_val = '0; in_rt_val = 32'h000000F1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sll_in_ready got %h want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sll_early_valid got %h want 0", out_valid); end
        n_cmp++; if (sh_A !== 32'h000000F1) begin n_err++; $display("FAIL sll_sh_A got %h want 000000f1", sh_A); end
        n_cmp++; if ({sh_B, sh_Shiftop} !== {5'd4, 2'b00}) begin n_err++; $display("FAIL sll_sh_ctrl got %h want %h", {sh_B, sh_Shiftop}, {5'd4, 2'b00}); end
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sll_valid got %h want 1", out_valid); end
        n_cmp++; if (out_result !== 32'h00000F10) begin n_err++; $display("FAIL sll_result got %h want 00000f10", out_result); end
        n_cmp++; if ({out_waddr, out_wen, out_illegal} !== {5'd3, 1'b1, 1'b0}) begin n_err++; $display("FAIL sll_ctrl got %h want %h", {out_waddr, out_wen, out_illegal}, {5'd3, 1'b1, 1'b0}); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sll_drain got %h want 0", out_valid); end
    endtask

    task automatic test_sra_srlv();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00021A03; in_rs_val = '0; in_rt_val = 32'h80000000;
        step();
        n_cmp++; if ({sh_B, sh_Shiftop} !== {5'd8, 2'b11}) begin n_err++; $display("FAIL sra_sh_ctrl got %h want %h", {sh_B, sh_Shiftop}, {5'd8, 2'b11}); end
        in_inst = 32'h00221806; in_rs_val = 32'hFFFFFFE4; in_rt_val = 32'h80000000;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_result !== 32'hFF800000 || out_valid !== 1'b1) begin n_err++; $display("FAIL sra_result got %h/%h want ff800000/1", out_result, out_valid); end
        n_cmp++; if ({sh_B, sh_Shiftop} !== {5'd4, 2'b01}) begin n_err++; $display("FAIL srlv_sh_ctrl got %h want %h", {sh_B, sh_Shiftop}, {5'd4, 2'b01}); end
        step();
        n_cmp++; if (out_result !== 32'h08000000 || out_valid !== 1'b1) begin n_err++; $display("FAIL srlv_result got %h/%h want 08000000/1", out_result, out_valid); end
        step();
    endtask

    task automatic test_boundary();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00021FC0; in_rs_val = '0; in_rt_val = 32'h00000001;
        step();
        n_cmp++; if (sh_B !== 5'd31) begin n_err++; $display("FAIL sa31_sh_B got %h want 1f", sh_B); end
        in_inst = 32'h00221807; in_rs_val = 32'h00000020; in_rt_val = 32'h80000000;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_result !== 32'h80000000) begin n_err++; $display("FAIL sa31_result got %h want 80000000", out_result); end
        n_cmp++; if ({sh_B, sh_Shiftop} !== {5'd0, 2'b11}) begin n_err++; $display("FAIL srav_sh_ctrl got %h want %h", {sh_B, sh_Shiftop}, {5'd0, 2'b11}); end
        step();
        n_cmp++; if (out_result !== 32'h80000000 || out_valid !== 1'b1) begin n_err++; $display("FAIL srav_result got %h/%h want 80000000/1", out_result, out_valid); end
        step();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00221821; in_rs_val = 32'h1; in_rt_val = 32'h2;
        step();
        n_cmp++; if ({sh_A, sh_B, sh_Shiftop} !== 39'h0) begin n_err++; $display("FAIL ill_sh got %h want 0", {sh_A, sh_B, sh_Shiftop}); end
        in_inst = 32'h00020100; in_rs_val = '0; in_rt_val = 32'h5;
        step();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_illegal, out_wen} !== 3'b110) begin n_err++; $display("FAIL ill_flags got %b want 110", {out_valid, out_illegal, out_wen}); end
        n_cmp++; if (out_result !== 32'h0) begin n_err++; $display("FAIL ill_result got %h want 0", out_result); end
        step();
        n_cmp++; if ({out_valid, out_illegal, out_wen} !== 3'b100) begin n_err++; $display("FAIL rd0_flags got %b want 100", {out_valid, out_illegal, out_wen}); end
        n_cmp++; if (out_result !== 32'h50 || out_waddr !== 5'd0) begin n_err++; $display("FAIL rd0_result got %h/%h want 50/0", out_result, out_waddr); end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00021900; in_rs_val = '0; in_rt_val = 32'h1;
        step();
        in_inst = 32'h00022100; in_rt_val = 32'h2;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1 got %h want 1", in_ready); end
        step();
        in_inst = 32'h00022900; in_rt_val = 32'h3;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full got %h want 0", in_ready); end
        n_cmp++; if ({out_valid, out_result, out_waddr} !== {1'b1, 32'h10, 5'd3}) begin n_err++; $display("FAIL b2b_head got %h want %h", {out_valid, out_result, out_waddr}, {1'b1, 32'h10, 5'd3}); end
        step();
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready got %h want 0", in_ready); end
        n_cmp++; if ({out_valid, out_result, out_waddr} !== {1'b1, 32'h10, 5'd3}) begin n_err++; $display("FAIL b2b_hold_out got %h want %h", {out_valid, out_result, out_waddr}, {1'b1, 32'h10, 5'd3}); end
        n_cmp++; if (sh_A !== 32'h2) begin n_err++; $display("FAIL b2b_hold_sh got %h want 2", sh_A); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_release got %h want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_result, out_waddr} !== {1'b1, 32'h20, 5'd4}) begin n_err++; $display("FAIL b2b_second got %h want %h", {out_valid, out_result, out_waddr}, {1'b1, 32'h20, 5'd4}); end
        step();
        n_cmp++; if ({out_valid, out_result, out_waddr} !== {1'b1, 32'h30, 5'd5}) begin n_err++; $display("FAIL b2b_third got %h want %h", {out_valid, out_result, out_waddr}, {1'b1, 32'h30, 5'd5}); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %h want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00021900; in_rs_val = '0; in_rt_val = 32'h1;
        step();
        in_inst = 32'h00022100; in_rt_val = 32'h2;
        step();
        flush = 1'b1; in_inst = 32'h00022900; in_rt_val = 32'h3;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_in_ready got %h want 0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid got %h want 0", out_valid); end
        n_cmp++; if (out_result !== 32'h10) begin n_err++; $display("FAIL fl_data_hold got %h want 10", out_result); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_no_accept got %h want 0", out_valid); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_cmp++; if ({out_valid, out_result, out_waddr} !== {1'b1, 32'h30, 5'd5}) begin n_err++; $display("FAIL fl_next got %h want %h", {out_valid, out_result, out_waddr}, {1'b1, 32'h30, 5'd5}); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_drain got %h want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00021900; in_rs_val = '0; in_rt_val = 32'h1;
        step();
        in_inst = 32'h00022100; in_rt_val = 32'h2;
        step();
        rst = 1'b1; in_inst = 32'h00022900; in_rt_val = 32'h3;
        step();
        n_cmp++; if ({out_valid, out_result, out_waddr, out_wen, out_illegal} !== 40'h0) begin n_err++; $display("FAIL rm_out got %h want 0", {out_valid, out_result, out_waddr, out_wen, out_illegal}); end
        n_cmp++; if ({sh_A, sh_B, sh_Shiftop} !== 39'h0) begin n_err++; $display("FAIL rm_sh got %h want 0", {sh_A, sh_B, sh_Shiftop}); end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rm_in_ready got %h want 1", in_ready); end
        in_valid = 1'b1; in_inst = 32'h00021900; in_rt_val = 32'h7;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_no_stale got %h want 0", out_valid); end
        step();
        n_cmp++; if ({out_valid, out_result, out_waddr} !== {1'b1, 32'h70, 5'd3}) begin n_err++; $display("FAIL rm_next got %h want %h", {out_valid, out_result, out_waddr}, {1'b1, 32'h70, 5'd3}); end
        step();
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_srlv();
        test_boundary();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
